ccip_c1_wr_issue: RTL and testbench

- Downstream stage of the server's CCI-P write-request port.
- Accepts cache-line write requests (address, mdata, 512-bit data) with a valid/ready handshake and buffers them in a small FIFO.
- Drives the CCI-P C1 TX channel under almost-full backpressure and an outstanding-write cap.
- Matches C1 write responses to completions for the server, and supports a flush (drain) operation so software can fence writes.

---
 rtl/ccip_c1_wr_pkg.sv | 25 ++
 rtl/ccip_c1_wr_issue_fifo.sv | 47 ++++
 rtl/ccip_c1_wr_issue.sv | 136 +++++++++++++
 tb/tb_ccip_c1_wr_issue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_c1_wr_pkg.sv
// Shared types and constants for the CCI-P C1 write-issue stage.
package ccip_c1_wr_pkg;

   localparam int C1_MDATA_W = 16;
   localparam int CL_ADDR_W  = 42;
   localparam int CL_DATA_W  = 512;

   typedef struct packed {
      logic [CL_ADDR_W-1:0]  addr;
      logic [C1_MDATA_W-1:0] mdata;
      logic [CL_DATA_W-1:0]  data;
   } wr_req_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   // Host addresses beyond the 42-bit cache-line space cannot be expressed on C1.
   function automatic logic addr_overflow(input logic [63:0] addr);
      return |addr[63:CL_ADDR_W];
   endfunction

endpackage

// File: rtl/ccip_c1_wr_issue_fifo.sv
// Request buffer: synchronous FIFO of wr_req_t; only the pointers are reset.
module c1_req_fifo
   import ccip_c1_wr_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wr_req_t wdata,
   input  logic    pop,
   output wr_req_t rdata,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   wr_req_t        mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ccip_c1_wr_issue.sv
// CCI-P C1 write-issue stage: buffers server writes, issues them under
// almost-full and outstanding-cap limits, returns completions, supports flush.
module ccip_c1_wr_issue
   import ccip_c1_wr_pkg::*;
#(
   parameter int DEPTH           = 8,
   parameter int MAX_OUTSTANDING = 64,
   parameter int MDATA_W         = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [63:0]           req_addr,
   input  logic [MDATA_W-1:0]    req_mdata,
   input  logic [CL_DATA_W-1:0]  req_data,
   output logic                  tx_valid,
   output logic [CL_ADDR_W-1:0]  tx_addr,
   output logic [C1_MDATA_W-1:0] tx_mdata,
   output logic [CL_DATA_W-1:0]  tx_data,
   input  logic                  tx_alm_full,
   input  logic                  rsp_valid,
   input  logic [C1_MDATA_W-1:0] rsp_mdata,
   output logic                  done_valid,
   output logic [MDATA_W-1:0]    done_mdata,
   input  logic                  flush_req,
   output logic                  flush_done,
   output logic [6:0]            outstanding,
   output logic [1:0]            err
);

   localparam logic [6:0] MAX_OUT = 7'(MAX_OUTSTANDING);

   fsm_t    state;
   wr_req_t push_req;
   wr_req_t head;
   logic    fifo_full;
   logic    fifo_empty;
   logic    push;
   logic    issue;
   logic    unused_rsp_bits;

   assign req_ready = (state == RUN) && !fifo_full;
   assign push      = req_valid && req_ready;
   // An entry pushed this cycle is not visible in fifo_empty until the next.
   assign issue     = !fifo_empty && !tx_alm_full && (outstanding < MAX_OUT);

   always_comb begin
      push_req       = '0;
      push_req.addr  = req_addr[CL_ADDR_W-1:0];
      push_req.mdata = C1_MDATA_W'(req_mdata);
      push_req.data  = req_data;
   end

   c1_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_req),
      .pop   (issue),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_addr  <= '0;
         tx_mdata <= '0;
         tx_data  <= '0;
      end else begin
         tx_valid <= issue;
         if (issue) begin
            tx_addr  <= head.addr;
            tx_mdata <= head.mdata;
            tx_data  <= head.data;
         end
      end
   end

   // Issue and response in the same cycle cancel; a response with nothing
   // outstanding is a protocol error and leaves the count at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
         err         <= '0;
      end else begin
         unique case ({issue, rsp_valid})
            2'b10: outstanding <= outstanding + 7'd1;
            2'b01: begin
               if (outstanding == 7'd0) err[0] <= 1'b1;
               else                     outstanding <= outstanding - 7'd1;
            end
            default: ;
         endcase
         if (push && addr_overflow(req_addr)) err[1] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_valid <= 1'b0;
         done_mdata <= '0;
      end else begin
         done_valid <= rsp_valid;
         if (rsp_valid) done_mdata <= rsp_mdata[MDATA_W-1:0];
      end
   end

   // tx_valid is part of the drain test so the last line has left the stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         unique case (state)
            RUN:   if (flush_req) state <= DRAIN;
            DRAIN: begin
               if (fifo_empty && (outstanding == 7'd0) && !tx_valid) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end
            end
            DONE:    state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   assign unused_rsp_bits = &{1'b0, rsp_mdata};

endmodule

// File: tb/tb_ccip_c1_wr_issue.sv
// Directed self-checking bench for ccip_c1_wr_issue (cap of 4 outstanding).
module tb_ccip_c1_wr_issue;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [63:0]  req_addr = '0;
   logic [13:0]  req_mdata = '0;
   logic [511:0] req_data = '0;
   logic         tx_valid;
   logic [41:0]  tx_addr;
   logic [15:0]  tx_mdata;
   logic [511:0] tx_data;
   logic         tx_alm_full = 1'b0;
   logic         rsp_valid = 1'b0;
   logic [15:0]  rsp_mdata = '0;
   logic         done_valid;
   logic [13:0]  done_mdata;
   logic         flush_req = 1'b0;
   logic         flush_done;
   logic [6:0]   outstanding;
   logic [1:0]   err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ccip_c1_wr_issue #(
      .DEPTH           (8),
      .MAX_OUTSTANDING (4),
      .MDATA_W         (14)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_mdata   (req_mdata),
      .req_data    (req_data),
      .tx_valid    (tx_valid),
      .tx_addr     (tx_addr),
      .tx_mdata    (tx_mdata),
      .tx_data     (tx_data),
      .tx_alm_full (tx_alm_full),
      .rsp_valid   (rsp_valid),
      .rsp_mdata   (rsp_mdata),
      .done_valid  (done_valid),
      .done_mdata  (done_mdata),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .outstanding (outstanding),
      .err         (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] mk_data(input int i);
      logic [31:0] w;
      w = 32'hC3C3_0000 ^ 32'(i);
      return {16{w}};
   endfunction

   task automatic set_req(input logic v, input logic [63:0] a, input logic [13:0] m,
                          input logic [511:0] d);
      req_valid = v;
      req_addr  = a;
      req_mdata = m;
      req_data  = d;
   endtask

   task automatic do_reset();
      set_req(1'b0, '0, '0, '0);
      tx_alm_full = 1'b0;
      rsp_valid   = 1'b0;
      flush_req   = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
      total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
      total++; if (err !== 2'b00) begin bad++; $display("FAIL reset_err got=%0b exp=00", err); end
      total++; if ({done_valid, flush_done} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%0b exp=00", {done_valid, flush_done}); end
      total++; if (tx_addr !== 42'd0 || tx_mdata !== 16'd0 || tx_data !== 512'd0) begin bad++; $display("FAIL reset_tx_bus addr=%0h mdata=%0h exp=0", tx_addr, tx_mdata); end
      do_reset();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
   endtask

   task automatic test_single();
      logic [511:0] d;
      d = {16{32'hA5A5_A5A5}};
      do_reset();
      set_req(1'b1, 64'h1000, 14'h005, d);
      tick();
      set_req(1'b0, '0, '0, '0);
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_early tx_valid=%0b exp=0", tx_valid); end
      tick();
      total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", tx_valid); end
      total++; if (tx_addr !== 42'h1000) begin bad++; $display("FAIL single_addr got=%0h exp=1000", tx_addr); end
      total++; if (tx_mdata !== 16'h0005) begin bad++; $display("FAIL single_mdata got=%0h exp=0005", tx_mdata); end
      total++; if (tx_data !== d) begin bad++; $display("FAIL single_data got=%0h exp=%0h", tx_data, d); end
      total++; if (outstanding !== 7'd1) begin bad++; $display("FAIL single_out got=%0d exp=1", outstanding); end
      tick();
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_onepulse tx_valid=%0b exp=0", tx_valid); end
      rsp_valid = 1'b1;
      rsp_mdata = 16'h0005;
      tick();
      rsp_valid = 1'b0;
      total++; if (done_valid !== 1'b1 || done_mdata !== 14'h005) begin bad++; $display("FAIL single_done valid=%0b mdata=%0h exp=1/005", done_valid, done_mdata); end
      total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL single_out_rsp got=%0d exp=0", outstanding); end
      tick();
      total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%0b exp=0", done_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      tx_alm_full = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_req(1'b1, 64'h2000 + 64'(i * 64), 14'(8'h30 + i), mk_data(i));
         tick();
         total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d tx_valid=%0b exp=0", i, tx_valid); end
      end
      set_req(1'b0, '0, '0, '0);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b exp=0", req_ready); end
      total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL bp_out_held got=%0d exp=0", outstanding); end
      tx_alm_full = 1'b0;
      // Answer each line as it appears so the cap never throttles the burst.
      for (int i = 0; i < 8; i++) begin
         tick();
         total++; if (tx_valid !== 1'b1 || tx_mdata !== 16'(8'h30 + i)) begin bad++; $display("FAIL bp_issue_%0d valid=%0b mdata=%0h exp=1/%0h", i, tx_valid, tx_mdata, 8'h30 + i); end
         total++; if (tx_addr !== 42'h2000 + 42'(i * 64) || tx_data !== mk_data(i)) begin bad++; $display("FAIL bp_payload_%0d addr=%0h exp=%0h", i, tx_addr, 42'h2000 + 42'(i * 64)); end
         rsp_valid = 1'b1;
         rsp_mdata = 16'(8'h30 + i);
      end
      tick();
      rsp_valid = 1'b0;
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL bp_after got=%0b exp=0", tx_valid); end
      total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL bp_out_end got=%0d exp=0", outstanding); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_end got=%0b exp=1", req_ready); end
   endtask

   task automatic test_cap();
      int n;
      n = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_req(1'b1, 64'h4000 + 64'(i * 64), 14'(8'h10 + i), mk_data(i + 16));
         tick();
         if (tx_valid === 1'b1) n++;
      end
      set_req(1'b0, '0, '0, '0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (tx_valid === 1'b1) n++;
      end
      total++; if (n !== 4) begin bad++; $display("FAIL cap_issued got=%0d exp=4", n); end
      total++; if (outstanding !== 7'd4) begin bad++; $display("FAIL cap_out got=%0d exp=4", outstanding); end
      rsp_valid = 1'b1;
      rsp_mdata = 16'h0010;
      tick();
      rsp_valid = 1'b0;
      total++; if (tx_valid !== 1'b0 || outstanding !== 7'd3) begin bad++; $display("FAIL cap_rsp valid=%0b out=%0d exp=0/3", tx_valid, outstanding); end
      tick();
      total++; if (tx_valid !== 1'b1 || tx_mdata !== 16'h0014) begin bad++; $display("FAIL cap_fifth valid=%0b mdata=%0h exp=1/0014", tx_valid, tx_mdata); end
      total++; if (outstanding !== 7'd4) begin bad++; $display("FAIL cap_out_again got=%0d exp=4", outstanding); end
      tick();
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL cap_sixth_blocked got=%0b exp=0", tx_valid); end
   endtask

   // Continues from test_cap: 4 outstanding, one line (mdata 0x15) queued.
   task automatic test_simultaneous();
      rsp_valid = 1'b1;
      rsp_mdata = 16'h0011;
      tick();
      total++; if (outstanding !== 7'd3 || tx_valid !== 1'b0) begin bad++; $display("FAIL sim_pre out=%0d valid=%0b exp=3/0", outstanding, tx_valid); end
      rsp_mdata = 16'h0012;
      tick();
      total++; if (outstanding !== 7'd3) begin bad++; $display("FAIL sim_both out=%0d exp=3", outstanding); end
      total++; if (tx_valid !== 1'b1 || tx_mdata !== 16'h0015) begin bad++; $display("FAIL sim_issue valid=%0b mdata=%0h exp=1/0015", tx_valid, tx_mdata); end
      for (int i = 0; i < 3; i++) begin
         rsp_mdata = 16'(8'h13 + i);
         tick();
      end
      rsp_valid = 1'b0;
      total++; if (outstanding !== 7'd0 || err !== 2'b00) begin bad++; $display("FAIL sim_drained out=%0d err=%0b exp=0/00", outstanding, err); end
      total++; if (done_mdata !== 14'h015) begin bad++; $display("FAIL sim_done_mdata got=%0h exp=015", done_mdata); end
      rsp_valid = 1'b1;
      rsp_mdata = 16'h3FFF;
      tick();
      rsp_valid = 1'b0;
      total++; if (err !== 2'b01 || outstanding !== 7'd0) begin bad++; $display("FAIL sim_underflow err=%0b out=%0d exp=01/0", err, outstanding); end
      tick();
      total++; if (err !== 2'b01) begin bad++; $display("FAIL sim_err_sticky got=%0b exp=01", err); end
   endtask

   task automatic test_addr();
      do_reset();
      set_req(1'b1, 64'h0000_03FF_FFFF_FFC0, 14'h006, mk_data(40));
      tick();
      set_req(1'b1, 64'h0400_0000_0000_3040, 14'h007, mk_data(41));
      total++; if (err !== 2'b00) begin bad++; $display("FAIL addr_top_bit_ok err=%0b exp=00", err); end
      tick();
      set_req(1'b0, '0, '0, '0);
      total++; if (tx_valid !== 1'b1 || tx_addr !== 42'h3FF_FFFF_FFC0) begin bad++; $display("FAIL addr_max valid=%0b addr=%0h exp=1/3ffffffffc0", tx_valid, tx_addr); end
      total++; if (err !== 2'b10) begin bad++; $display("FAIL addr_err got=%0b exp=10", err); end
      tick();
      total++; if (tx_valid !== 1'b1 || tx_addr !== 42'h3040 || tx_mdata !== 16'h0007) begin bad++; $display("FAIL addr_trunc valid=%0b addr=%0h mdata=%0h exp=1/3040/0007", tx_valid, tx_addr, tx_mdata); end
   endtask

   task automatic test_flush();
      do_reset();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      total++; if (req_ready !== 1'b0 || flush_done !== 1'b0) begin bad++; $display("FAIL flush_idle_drain ready=%0b done=%0b exp=0/0", req_ready, flush_done); end
      tick();
      total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL flush_idle_done got=%0b exp=1", flush_done); end
      tick();
      total++; if (flush_done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL flush_idle_back done=%0b ready=%0b exp=0/1", flush_done, req_ready); end

      tx_alm_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, 64'h8000 + 64'(i * 64), 14'(8'h20 + i), mk_data(i + 8));
         tick();
      end
      set_req(1'b0, '0, '0, '0);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", req_ready); end
      tx_alm_full = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      total++; if (outstanding !== 7'd3 || req_ready !== 1'b0 || flush_done !== 1'b0) begin bad++; $display("FAIL flush_issued out=%0d ready=%0b done=%0b exp=3/0/0", outstanding, req_ready, flush_done); end
      rsp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rsp_mdata = 16'(8'h20 + i);
         tick();
      end
      rsp_valid = 1'b0;
      total++; if (flush_done !== 1'b0 || outstanding !== 7'd0) begin bad++; $display("FAIL flush_wait done=%0b out=%0d exp=0/0", flush_done, outstanding); end
      tick();
      total++; if (flush_done !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL flush_done done=%0b ready=%0b exp=1/0", flush_done, req_ready); end
      tick();
      total++; if (flush_done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL flush_resume done=%0b ready=%0b exp=0/1", flush_done, req_ready); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tx_alm_full = 1'b1;
      for (int i = 0; i < 7; i++) begin
         set_req(1'b1, (i == 0) ? 64'h0000_0400_0000_0000 : 64'(i * 64), 14'(8'h40 + i), mk_data(i + 24));
         tick();
      end
      set_req(1'b0, '0, '0, '0);
      tx_alm_full = 1'b0;
      tick();
      tick();
      tx_alm_full = 1'b1;
      total++; if (outstanding !== 7'd2 || tx_valid !== 1'b1 || err !== 2'b10) begin bad++; $display("FAIL rmid_pre out=%0d valid=%0b err=%0b exp=2/1/10", outstanding, tx_valid, err); end
      rsp_valid = 1'b1;
      rsp_mdata = 16'h0040;
      #2;
      rst = 1'b1;
      #1;
      total++; if (tx_valid !== 1'b0 || outstanding !== 7'd0 || err !== 2'b00) begin bad++; $display("FAIL rmid_async valid=%0b out=%0d err=%0b exp=0/0/00", tx_valid, outstanding, err); end
      total++; if (tx_addr !== 42'd0 || tx_mdata !== 16'd0 || done_valid !== 1'b0) begin bad++; $display("FAIL rmid_bus addr=%0h mdata=%0h done=%0b exp=0", tx_addr, tx_mdata, done_valid); end
      rsp_valid = 1'b0;
      tx_alm_full = 1'b0;
      tick();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (tx_valid !== 1'b0 || outstanding !== 7'd0) begin bad++; $display("FAIL rmid_stale_%0d valid=%0b out=%0d exp=0/0", i, tx_valid, outstanding); end
      end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b exp=1", req_ready); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_cap();
      test_simultaneous();
      test_addr();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
